filtro_distancia: RTL and testbench
===================================

FILTRO_DISTANCIA -- requirements
Module: filtro_distancia

Interface
REQ-001 Parameter CLOCK_FREQ, default 50000000: system clock frequency in Hz.
REQ-002 Parameter UMBRAL_CERCA, default 20: near threshold in cm.
REQ-003 Parameter UMBRAL_LEJOS, default 25: far threshold in cm; SHALL be greater than UMBRAL_CERCA.
REQ-004 Parameter DIST_MAX, default 400: clamp ceiling in cm.
REQ-005 Parameter TIMEOUT_MS, default 100: time without a sample before a fault is declared.
REQ-006 clk  input  1  system clock, rising edge.
REQ-007 rst  input  1  reset; asynchronous, active-high.
REQ-008 distancia_cm  input  16  raw distance from the ultrasonic measurement stage.
REQ-009 dato_valido  input  1  one-cycle strobe; distancia_cm is valid in that cycle.
REQ-010 promedio_cm  output  16  filtered distance, registered.
REQ-011 promedio_valido  output  1  high while promedio_cm reflects a full 4-sample window.
REQ-012 objeto_cerca  output  1  hysteretic proximity flag.
REQ-013 falla_sensor  output  1  high while in the FALLA state.

Function
REQ-014 Sample acceptance: a sample SHALL be accepted on every clk edge with dato_valido=1; there is no backpressure.
REQ-015 Clamp: an accepted value greater than DIST_MAX SHALL be replaced by DIST_MAX before any further processing.
REQ-016 Window: accepted values SHALL enter a 4-deep shift window with an 18-bit running sum (add new value, subtract evicted value).
REQ-017 Average: promedio_cm SHALL equal sum>>2 (truncating) and SHALL be registered 1 cycle after the accepting edge.
REQ-018 States: the FSM SHALL have exactly the states VACIO, LLENO and FALLA.
REQ-019 Fill count: VACIO SHALL count accepted samples 0..3; on the 4th accepted sample the FSM SHALL go to LLENO and promedio_valido SHALL rise together with the first valid promedio_cm.
REQ-020 VACIO outputs: promedio_valido=0 and promedio_cm=0.
REQ-021 Hysteresis: objeto_cerca SHALL be evaluated only on cycles where a new average is registered in LLENO.
REQ-022 Hysteresis set/clear: objeto_cerca SHALL be set when average <= UMBRAL_CERCA, cleared when average >= UMBRAL_LEJOS, and held otherwise.
REQ-023 Watchdog: a cycle counter SHALL clear on every accepted sample and increment otherwise, saturating at CLOCK_FREQ/1000*TIMEOUT_MS.
REQ-024 Timeout: on reaching the limit in VACIO or LLENO, the FSM SHALL enter FALLA.
REQ-025 FALLA entry: on entry, the window, sum, fill count, promedio_cm, promedio_valido and objeto_cerca SHALL clear, and falla_sensor SHALL be 1.
REQ-026 FALLA exit: an accepted sample in FALLA SHALL move the FSM to VACIO, with that sample counted as fill 1 and falla_sensor cleared on the same edge.
REQ-027 Simultaneous events: a sample accepted in the cycle the watchdog would reach its limit SHALL take priority; no fault is raised and the counter clears.
REQ-028 Continuity: back-to-back strobes on consecutive cycles SHALL each be accepted with no sample lost.

Reset
REQ-029 Reset assertion: asserting rst at any time, including mid-window, SHALL force VACIO, clear the window, sum, fill count and watchdog, and drive all outputs to 0.
REQ-030 Reset release: after rst deasserts, the first dato_valido SHALL count as fill 1.

Configuration
REQ-031 Macro: FILTRO_MEDIANA_EN SHALL control an optional median pre-filter.
REQ-032 Defined: each clamped sample SHALL be replaced by the median of it and the two previous clamped samples before entering the window.
REQ-033 Defined, start-up: the first two samples after reset or after leaving FALLA SHALL pass unfiltered; latency is unchanged.
REQ-034 Undefined: clamped samples SHALL enter the window directly, and no median logic SHALL be synthesised.

Verification
REQ-035 Fill and average: samples 10,20,30,40 -> promedio_valido rises 1 cycle after the 4th, promedio_cm=25; next sample 50 -> promedio_cm=35.
REQ-036 Hysteresis: steady 30 then steady 15 -> objeto_cerca=1; then steady 22 -> stays 1; then steady 26 -> objeto_cerca=0.
REQ-037 Clamp: samples 0xFFFF x4 -> promedio_cm=400.
REQ-038 Watchdog: no strobe for TIMEOUT_MS (small parameter on the bench) -> falla_sensor=1 and all other outputs 0; one strobe -> falla_sensor=0 with state VACIO.
REQ-039 Reset mid-window: rst after 2 samples -> all outputs 0; 4 new samples are needed before promedio_valido=1.
REQ-040 Median (macro defined): samples 20,20,300,20,20 -> the 300 is rejected and promedio_cm=20.

Source files
------------

// File: rtl/filtro_distancia_if.sv
// Bus bundle for the ultrasonic distance filter.
// Handshake: dato_valido is a one-cycle strobe qualifying distancia_cm; the
// filter has no ready signal and accepts every strobe on the rising edge.
// estado_dbg exposes the filter FSM state (0=VACIO, 1=LLENO, 2=FALLA).
interface filtro_distancia_if;
  logic [15:0] distancia_cm;
  logic        dato_valido;
  logic [15:0] promedio_cm;
  logic        promedio_valido;
  logic        objeto_cerca;
  logic        falla_sensor;
  logic [1:0]  estado_dbg;

  // Producer of raw samples / consumer of filtered results
  modport master (
    output distancia_cm, dato_valido,
    input  promedio_cm, promedio_valido, objeto_cerca, falla_sensor, estado_dbg
  );

  // The filter itself
  modport slave (
    input  distancia_cm, dato_valido,
    output promedio_cm, promedio_valido, objeto_cerca, falla_sensor, estado_dbg
  );
endinterface

// File: rtl/filtro_distancia.sv
// Distance filter: clamps raw ultrasonic samples, averages them over a
// 4-sample moving window, derives a hysteretic proximity flag and watches
// for a silent sensor. Optional median-of-3 pre-filter is enabled by
// defining FILTRO_MEDIANA_EN; the default build leaves it out entirely.
module filtro_distancia #(
  parameter int CLOCK_FREQ   = 50000000,
  parameter int UMBRAL_CERCA = 20,
  parameter int UMBRAL_LEJOS = 25,
  parameter int DIST_MAX     = 400,
  parameter int TIMEOUT_MS   = 100
) (
  input logic               clk,
  input logic               rst,
  filtro_distancia_if.slave bus
);

  localparam int LIMITE = CLOCK_FREQ / 1000 * TIMEOUT_MS;
  localparam int WD_W   = (LIMITE < 2) ? 1 : $clog2(LIMITE + 1);

  localparam logic [15:0]   DMAX   = 16'(DIST_MAX);
  localparam logic [15:0]   CERCA  = 16'(UMBRAL_CERCA);
  localparam logic [15:0]   LEJOS  = 16'(UMBRAL_LEJOS);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(LIMITE);

  typedef enum logic [1:0] {
    VACIO = 2'd0,
    LLENO = 2'd1,
    FALLA = 2'd2
  } estado_t;

  estado_t estado_q, estado_d;

  logic            acepta;
  logic [15:0]     recortado;
  logic [15:0]     filtrado;

  logic [WD_W-1:0] wd_q, wd_d;
  logic            expira;

  logic [3:0][15:0] win_q, win_d;
  logic [17:0]      suma_q, suma_d;
  logic [1:0]       fill_q, fill_d;
  logic [15:0]      prom_q, prom_d;
  logic             cerca_q, cerca_d;
  logic             entra_falla;

  assign acepta    = bus.dato_valido;
  assign recortado = (bus.distancia_cm > DMAX) ? DMAX : bus.distancia_cm;

`ifdef FILTRO_MEDIANA_EN
  // Two previous clamped samples and how many of them are meaningful
  logic [15:0] hist1_q, hist1_d;
  logic [15:0] hist2_q, hist2_d;
  logic [1:0]  mcnt_q, mcnt_d;

  function automatic logic [15:0] mediana3(input logic [15:0] a,
                                           input logic [15:0] b,
                                           input logic [15:0] c);
    logic [15:0] lo, hi, m;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    m  = (hi < c) ? hi : c;
    return (lo > m) ? lo : m;
  endfunction

  // Median selection and history update; history restarts after a fault
  always_comb begin
    hist1_d  = hist1_q;
    hist2_d  = hist2_q;
    mcnt_d   = mcnt_q;
    filtrado = (mcnt_q == 2'd2) ? mediana3(recortado, hist1_q, hist2_q) : recortado;
    if (entra_falla) begin
      hist1_d = '0;
      hist2_d = '0;
      mcnt_d  = '0;
    end else if (acepta) begin
      hist2_d = hist1_q;
      hist1_d = recortado;
      if (mcnt_q != 2'd2) mcnt_d = mcnt_q + 2'd1;
    end
  end

  // Median history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist1_q <= '0;
      hist2_q <= '0;
      mcnt_q  <= '0;
    end else begin
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
      mcnt_q  <= mcnt_d;
    end
  end
`else
  assign filtrado = recortado;
`endif

  // Watchdog: clears on a sample, otherwise counts up and saturates
  always_comb begin
    if (acepta)              wd_d = '0;
    else if (wd_q == WD_LIM) wd_d = wd_q;
    else                     wd_d = wd_q + 1'b1;
    expira = !acepta && (wd_d == WD_LIM);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado_q <= VACIO;
    else     estado_q <= estado_d;
  end

  // FSM next state; a sample always wins over an expiring watchdog
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      VACIO: begin
        if (acepta && fill_q == 2'd3) estado_d = LLENO;
        else if (expira)              estado_d = FALLA;
      end
      LLENO: begin
        if (expira) estado_d = FALLA;
      end
      FALLA: begin
        if (acepta) estado_d = VACIO;
      end
      default: estado_d = VACIO;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.falla_sensor    = (estado_q == FALLA);
    bus.promedio_valido = (estado_q == LLENO);
    bus.estado_dbg      = estado_q;
  end

  assign entra_falla     = (estado_q != FALLA) && (estado_d == FALLA);
  assign bus.promedio_cm = prom_q;
  assign bus.objeto_cerca = cerca_q;

  // Window, running sum, fill count, average and proximity flag
  always_comb begin
    win_d   = win_q;
    suma_d  = suma_q;
    fill_d  = fill_q;
    prom_d  = prom_q;
    cerca_d = cerca_q;
    if (entra_falla) begin
      win_d   = '0;
      suma_d  = '0;
      fill_d  = '0;
      prom_d  = '0;
      cerca_d = 1'b0;
    end else if (acepta) begin
      if (estado_q == FALLA) begin
        // Restart from an empty window with this sample as the first one
        win_d    = '0;
        win_d[0] = filtrado;
        suma_d   = 18'(filtrado);
        fill_d   = 2'd1;
        prom_d   = '0;
        cerca_d  = 1'b0;
      end else begin
        win_d  = {win_q[2:0], filtrado};
        suma_d = suma_q + 18'(filtrado) - 18'(win_q[3]);
        if (estado_q == VACIO) fill_d = fill_q + 2'd1;
        if (estado_d == LLENO) begin
          prom_d = suma_d[17:2];
          if (prom_d <= CERCA)      cerca_d = 1'b1;
          else if (prom_d >= LEJOS) cerca_d = 1'b0;
        end
      end
    end
  end

  // Datapath and watchdog registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q   <= '0;
      suma_q  <= '0;
      fill_q  <= '0;
      prom_q  <= '0;
      cerca_q <= 1'b0;
      wd_q    <= '0;
    end else begin
      win_q   <= win_d;
      suma_q  <= suma_d;
      fill_q  <= fill_d;
      prom_q  <= prom_d;
      cerca_q <= cerca_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_filtro_distancia.sv
// Bench for filtro_distancia: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_filtro_distancia;

  localparam int CLOCK_FREQ = 1000;
  localparam int TIMEOUT_MS = 40;
  localparam int LIM        = CLOCK_FREQ / 1000 * TIMEOUT_MS;
  localparam int CERCA      = 20;
  localparam int LEJOS      = 25;
  localparam int DMAX       = 400;
  localparam int ST_VACIO   = 0;
  localparam int ST_LLENO   = 1;
  localparam int ST_FALLA   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  filtro_distancia_if bus ();

  filtro_distancia #(
    .CLOCK_FREQ  (CLOCK_FREQ),
    .UMBRAL_CERCA(CERCA),
    .UMBRAL_LEJOS(LEJOS),
    .DIST_MAX    (DMAX),
    .TIMEOUT_MS  (TIMEOUT_MS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_win[$];     // filtered samples, newest first
  int m_hist[$];    // clamped samples for the median, newest first
  int m_idle;
  bit m_falla;
  int m_prom;
  bit m_valid;
  bit m_cerca;

  function automatic int med3(input int a, input int b, input int c);
    int s[3];
    s[0] = a; s[1] = b; s[2] = c;
    s.sort();
    return s[1];
  endfunction

  task automatic modelo_reset();
    m_win.delete();
    m_hist.delete();
    m_idle  = 0;
    m_falla = 0;
    m_prom  = 0;
    m_valid = 0;
    m_cerca = 0;
  endtask

  task automatic modelo_paso(input bit v, input int d);
    int x, f, s;
    if (v) begin
      x = (d > DMAX) ? DMAX : d;
      f = x;
`ifdef FILTRO_MEDIANA_EN
      if (m_hist.size() >= 2) f = med3(x, m_hist[0], m_hist[1]);
      m_hist.push_front(x);
      if (m_hist.size() > 2) void'(m_hist.pop_back());
`endif
      m_idle = 0;
      if (m_falla) begin
        m_falla = 0;
        m_win.delete();
      end
      m_win.push_front(f);
      if (m_win.size() > 4) void'(m_win.pop_back());
      if (m_win.size() == 4) begin
        s = 0;
        foreach (m_win[i]) s += m_win[i];
        m_prom  = s / 4;
        m_valid = 1;
        if (m_prom <= CERCA)      m_cerca = 1;
        else if (m_prom >= LEJOS) m_cerca = 0;
      end
    end else begin
      if (m_idle < LIM) m_idle++;
      if (m_idle == LIM && !m_falla) begin
        m_falla = 1;
        m_win.delete();
        m_hist.delete();
        m_prom  = 0;
        m_valid = 0;
        m_cerca = 0;
      end
    end
  endtask

  function automatic int estado_esperado();
    if (m_falla) return ST_FALLA;
    if (m_win.size() == 4) return ST_LLENO;
    return ST_VACIO;
  endfunction

  // Compare every output against the model
  task automatic comparar_todo();
    logic [15:0] e;
    exp_q.push_back(16'(m_prom));
    e = exp_q.pop_front();
    chequear("promedio_cm", 32'(bus.promedio_cm), 32'(e));
    chequear("promedio_valido", 32'(bus.promedio_valido), 32'(m_valid));
    chequear("objeto_cerca", 32'(bus.objeto_cerca), 32'(m_cerca));
    chequear("falla_sensor", 32'(bus.falla_sensor), 32'(m_falla));
    chequear("estado", 32'(bus.estado_dbg), 32'(estado_esperado()));
  endtask

  // ---------------- driver tasks ----------------
  task automatic ciclo(input bit v, input logic [15:0] d);
    bus.dato_valido  = v;
    bus.distancia_cm = d;
    @(posedge clk);
    modelo_paso(v, int'(d));
    #1;
    comparar_todo();
  endtask

  task automatic muestra(input logic [15:0] d);
    ciclo(1'b1, d);
  endtask

  task automatic ocioso(input int n);
    for (int i = 0; i < n; i++) ciclo(1'b0, 16'd0);
  endtask

  task automatic aplicar_reset();
    bus.dato_valido  = 1'b0;
    bus.distancia_cm = '0;
    rst = 1'b1;
    #2;
    chequear("rst_promedio", 32'(bus.promedio_cm), 32'd0);
    chequear("rst_valido", 32'(bus.promedio_valido), 32'd0);
    chequear("rst_cerca", 32'(bus.objeto_cerca), 32'd0);
    chequear("rst_falla", 32'(bus.falla_sensor), 32'd0);
    modelo_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.dato_valido  = 1'b0;
    bus.distancia_cm = '0;
    modelo_reset();
    @(posedge clk);
    #1;
    aplicar_reset();
    comparar_todo();

    // Fill and average
    muestra(16'd10); muestra(16'd20); muestra(16'd30);
    chequear("valido_antes_4", 32'(bus.promedio_valido), 32'd0);
    muestra(16'd40);
    chequear("prom_25", 32'(bus.promedio_cm), 32'd25);
    chequear("valido_4", 32'(bus.promedio_valido), 32'd1);
    muestra(16'd50);
    chequear("prom_35", 32'(bus.promedio_cm), 32'd35);

    // Hysteresis
    for (int i = 0; i < 6; i++) muestra(16'd30);
    chequear("cerca_30", 32'(bus.objeto_cerca), 32'd0);
    for (int i = 0; i < 6; i++) muestra(16'd15);
    chequear("cerca_15", 32'(bus.objeto_cerca), 32'd1);
    for (int i = 0; i < 6; i++) muestra(16'd22);
    chequear("cerca_22", 32'(bus.objeto_cerca), 32'd1);
    for (int i = 0; i < 6; i++) muestra(16'd26);
    chequear("cerca_26", 32'(bus.objeto_cerca), 32'd0);

    // Clamp
    for (int i = 0; i < 4; i++) muestra(16'hFFFF);
    chequear("clamp_400", 32'(bus.promedio_cm), 32'd400);

    // Sample on the edge the watchdog would expire: no fault
    ocioso(LIM - 1);
    muestra(16'd100);
    chequear("sin_falla_simult", 32'(bus.falla_sensor), 32'd0);

    // Watchdog fault and recovery
    ocioso(LIM);
    chequear("falla_1", 32'(bus.falla_sensor), 32'd1);
    chequear("falla_prom", 32'(bus.promedio_cm), 32'd0);
    chequear("falla_valido", 32'(bus.promedio_valido), 32'd0);
    chequear("falla_cerca", 32'(bus.objeto_cerca), 32'd0);
    ocioso(5);
    muestra(16'd60);
    chequear("sale_falla", 32'(bus.falla_sensor), 32'd0);
    chequear("sale_vacio", 32'(bus.estado_dbg), 32'(ST_VACIO));
    muestra(16'd60); muestra(16'd60);
    chequear("valido_3_tras_falla", 32'(bus.promedio_valido), 32'd0);
    muestra(16'd60);
    chequear("valido_4_tras_falla", 32'(bus.promedio_valido), 32'd1);

    // Reset mid-window
    for (int i = 0; i < 6; i++) muestra(16'd12);
    muestra(16'd70); muestra(16'd70);
    aplicar_reset();
    comparar_todo();
    muestra(16'd80); muestra(16'd80); muestra(16'd80);
    chequear("rst_3_muestras", 32'(bus.promedio_valido), 32'd0);
    muestra(16'd80);
    chequear("rst_4_muestras", 32'(bus.promedio_valido), 32'd1);
    chequear("rst_prom_80", 32'(bus.promedio_cm), 32'd80);

`ifdef FILTRO_MEDIANA_EN
    aplicar_reset();
    muestra(16'd20); muestra(16'd20); muestra(16'd300); muestra(16'd20); muestra(16'd20);
    chequear("mediana_20", 32'(bus.promedio_cm), 32'd20);
`endif

    // Randomized traffic, including occasional long silences
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        ocioso($urandom_range(LIM - 2, LIM + 5));
      end else if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 9) == 0) muestra(16'($urandom_range(401, 65535)));
        else                           muestra(16'($urandom_range(0, 60)));
      end else begin
        ocioso($urandom_range(1, 3));
      end
      if ($urandom_range(0, 199) == 0) aplicar_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
